// File: rtl/rd_dpram_ctl.sv
// ---------------------------------------------------------------------------
// rd_dpram_ctl
//
// Parametrised dual-port register file for the GPU/DSP register banks.
// Both ports share sys_clk and are strobed by the clka/clkb cycle enables.
// After reset a clear sequencer writes INIT_VALUE into every word, one word
// per cycle, and the user ports are ignored until it finishes.
//
// Optional feature macro: RD_DPRAM_BYPASS_EN
//   defined   : a read that hits an address being written in the same cycle
//               returns the newly written (collision-merged) bytes.
//   undefined : reads return the old stored word; no forwarding mux, so the
//               array stays inferable as block RAM.
//
// Parameters:
//   WIDTH      word width in bits (multiple of 8)
//   AW         address width, depth = 2^AW
//   INIT_VALUE value written to every word by the clear sequencer
//
// Ports:
//   sys_clk    sole clock, rising edge
//   reset      synchronous active-high reset, restarts the clear sequence
//   clka       port A cycle strobe
//   nwea       port A write enable, active low, qualified by clka
//   bea        port A byte enables, bit n covers da[8n+7:8n]
//   aa         port A address
//   da         port A write data
//   qa         port A registered read data, holds when clka is low
//   clkb/nweb/beb/ab/db/qb  port B, same meaning as port A
//   init_busy  high while the clear sequencer runs
// ---------------------------------------------------------------------------
module rd_dpram_ctl #(
    parameter int               WIDTH      = 32,
    parameter int               AW         = 6,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               clka,
    input  logic               nwea,
    input  logic [WIDTH/8-1:0] bea,
    input  logic [AW-1:0]      aa,
    input  logic [WIDTH-1:0]   da,
    output logic [WIDTH-1:0]   qa,
    input  logic               clkb,
    input  logic               nweb,
    input  logic [WIDTH/8-1:0] beb,
    input  logic [AW-1:0]      ab,
    input  logic [WIDTH-1:0]   db,
    output logic [WIDTH-1:0]   qb,
    output logic               init_busy
);

    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW:0]     clr_ptr;
    logic [AW:0]     clr_ptr_next;

    logic            clr_wr;
    logic            wr_a;
    logic            wr_b;
    logic            rd_a;
    logic            rd_b;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;

    // State register. The clear pointer carries one extra bit so the
    // terminal condition is simply its MSB; init_busy is registered from
    // the next state so it is already high in the reset cycle and drops
    // right after the last clear write.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_next;
            clr_ptr   <= clr_ptr_next;
            init_busy <= (state_next == CLEAR);
        end
    end

    // Next-state and access qualification. All user accesses are masked
    // while clearing and in the reset cycle itself.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        clr_wr       = 1'b0;
        wr_a         = 1'b0;
        wr_b         = 1'b0;
        rd_a         = 1'b0;
        rd_b         = 1'b0;
        if (!reset) begin
            case (state)
                CLEAR: begin
                    clr_wr       = 1'b1;
                    clr_ptr_next = clr_ptr + (AW+1)'(1);
                    if (clr_ptr_next[AW]) begin
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    wr_a = clka & ~nwea;
                    wr_b = clkb & ~nweb;
                    rd_a = clka;
                    rd_b = clkb;
                end
                default: begin
                    state_next = CLEAR;
                end
            endcase
        end
    end

    // Storage array. Port B bytes are assigned first and port A bytes last,
    // so on a same-address collision a byte enabled on both ports ends up
    // with port A's data while singly-enabled bytes take their own port.
    always_ff @(posedge sys_clk) begin
        if (clr_wr) begin
            mem[clr_ptr[AW-1:0]] <= INIT_VALUE;
        end else begin
            for (int n = 0; n < NB; n++) begin
                if (wr_b && beb[n]) begin
                    mem[ab][8*n +: 8] <= db[8*n +: 8];
                end
                if (wr_a && bea[n]) begin
                    mem[aa][8*n +: 8] <= da[8*n +: 8];
                end
            end
        end
    end

`ifdef RD_DPRAM_BYPASS_EN
    // Write-first forwarding: bytes being written to the read address this
    // cycle are replaced by the merged write data, port A taking priority.
    always_comb begin
        rd_data_a = mem[aa];
        rd_data_b = mem[ab];
        for (int n = 0; n < NB; n++) begin
            if (wr_b && beb[n] && (ab == aa)) begin
                rd_data_a[8*n +: 8] = db[8*n +: 8];
            end
            if (wr_a && bea[n]) begin
                rd_data_a[8*n +: 8] = da[8*n +: 8];
            end
            if (wr_b && beb[n]) begin
                rd_data_b[8*n +: 8] = db[8*n +: 8];
            end
            if (wr_a && bea[n] && (aa == ab)) begin
                rd_data_b[8*n +: 8] = da[8*n +: 8];
            end
        end
    end
`else
    // Read-first: the stored word before this cycle's writes.
    assign rd_data_a = mem[aa];
    assign rd_data_b = mem[ab];
`endif

    // Output registers. Forced to zero while clearing; otherwise they only
    // load on a strobed cycle and hold their value in between.
    always_ff @(posedge sys_clk) begin
        if (reset || (state == CLEAR)) begin
            qa <= '0;
            qb <= '0;
        end else begin
            if (rd_a) begin
                qa <= rd_data_a;
            end
            if (rd_b) begin
                qb <= rd_data_b;
            end
        end
    end

endmodule

// File: tb/tb_rd_dpram_ctl.sv
// ---------------------------------------------------------------------------
// tb_rd_dpram_ctl
//
// Directed testbench for rd_dpram_ctl (WIDTH=32, AW=6, INIT_VALUE=0).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, well away from the active edge.
// Expected read-during-write data depends on RD_DPRAM_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_rd_dpram_ctl;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        clka;
    logic        nwea;
    logic [3:0]  bea;
    logic [5:0]  aa;
    logic [31:0] da;
    logic [31:0] qa;
    logic        clkb;
    logic        nweb;
    logic [3:0]  beb;
    logic [5:0]  ab;
    logic [31:0] db;
    logic [31:0] qb;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    rd_dpram_ctl #(
        .WIDTH      (32),
        .AW         (6),
        .INIT_VALUE (32'h0)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .clka      (clka),
        .nwea      (nwea),
        .bea       (bea),
        .aa        (aa),
        .da        (da),
        .qa        (qa),
        .clkb      (clkb),
        .nweb      (nweb),
        .beb       (beb),
        .ab        (ab),
        .db        (db),
        .qb        (qb),
        .init_busy (init_busy)
    );

    // 10-unit clock period.
    always #5 sys_clk = ~sys_clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive both ports in one call.
    task automatic applyStimulus(
        input logic        ca,
        input logic        nwa,
        input logic [3:0]  ba,
        input logic [5:0]  a_addr,
        input logic [31:0] a_data,
        input logic        cb,
        input logic        nwb,
        input logic [3:0]  bb,
        input logic [5:0]  b_addr,
        input logic [31:0] b_data
    );
        clka = ca;
        nwea = nwa;
        bea  = ba;
        aa   = a_addr;
        da   = a_data;
        clkb = cb;
        nweb = nwb;
        beb  = bb;
        ab   = b_addr;
        db   = b_data;
    endtask

    task automatic idlePorts();
        applyStimulus(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 1'b1, 4'h0, 6'd0, 32'h0);
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        int          cnt;
        int          bad_a;
        int          bad_b;
        logic [31:0] exp_rdw;
        logic [31:0] exp_part;

`ifdef RD_DPRAM_BYPASS_EN
        exp_rdw  = 32'hDEADBEEF;
        exp_part = 32'hDEADBE55;
`else
        exp_rdw  = 32'h00000000;
        exp_part = 32'hDEADBEEF;
`endif

        // ---- Reset and first clear ----
        reset = 1'b1;
        idlePorts();
        tick();
        checkOutput("reset_qa", qa, 32'h0);
        checkOutput("reset_qb", qb, 32'h0);
        checkOutput("reset_init_busy", {31'b0, init_busy}, 32'h1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h0, 6'd7, 32'h0, 1'b1, 1'b1, 4'h0, 6'd9, 32'h0);
        cnt   = 0;
        bad_a = 0;
        while (init_busy && cnt < 200) begin
            tick();
            cnt++;
            if (init_busy && (qa !== 32'h0 || qb !== 32'h0)) bad_a++;
        end
        checkOutput("clear1_cycles", cnt, 32'd64);
        checkOutput("clear1_q_nonzero_count", bad_a, 32'd0);

        // ---- Every address reads INIT_VALUE ----
        bad_a = 0;
        bad_b = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 1'b1, 4'h0, 6'(i), 32'h0, 1'b1, 1'b1, 4'h0, 6'(63 - i), 32'h0);
            tick();
            if (qa !== 32'h0) bad_a++;
            if (qb !== 32'h0) bad_b++;
        end
        checkOutput("full_read_a_bad_count", bad_a, 32'd0);
        checkOutput("full_read_b_bad_count", bad_b, 32'd0);

        // ---- Byte-enable write ----
        applyStimulus(1'b1, 1'b0, 4'hF, 6'd5, 32'h11223344, 1'b0, 1'b1, 4'h0, 6'd0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'b0101, 6'd5, 32'hAABBCCDD, 1'b0, 1'b1, 4'h0, 6'd0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 1'b1, 4'h0, 6'd5, 32'h0);
        tick();
        checkOutput("byte_write_qb", qb, 32'h11BB33DD);

        // ---- Write collision at addr 9 ----
        applyStimulus(1'b1, 1'b0, 4'b0011, 6'd9, 32'hAAAAAAAA, 1'b1, 1'b0, 4'hF, 6'd9, 32'hBBBBBBBB);
        tick();
        applyStimulus(1'b1, 1'b1, 4'h0, 6'd9, 32'h0, 1'b0, 1'b1, 4'h0, 6'd0, 32'h0);
        tick();
        checkOutput("collision_qa", qa, 32'hBBBBAAAA);

        // ---- Read during write at addr 3 ----
        applyStimulus(1'b1, 1'b0, 4'hF, 6'd3, 32'hDEADBEEF, 1'b1, 1'b1, 4'h0, 6'd3, 32'h0);
        tick();
        checkOutput("rdw_cross_qb", qb, exp_rdw);
        checkOutput("rdw_same_qa", qa, exp_rdw);
        applyStimulus(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 1'b1, 4'h0, 6'd3, 32'h0);
        tick();
        checkOutput("rdw_next_qb", qb, 32'hDEADBEEF);
        // Partial write: only byte 0 is forwarded, the rest is stored data.
        applyStimulus(1'b1, 1'b0, 4'b0001, 6'd3, 32'h00000055, 1'b1, 1'b1, 4'h0, 6'd3, 32'h0);
        tick();
        checkOutput("rdw_partial_qb", qb, exp_part);

        // ---- Hold when strobe is low ----
        applyStimulus(1'b1, 1'b0, 4'hF, 6'd20, 32'h00001234, 1'b0, 1'b1, 4'h0, 6'd0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'h0, 6'd20, 32'h0, 1'b1, 1'b1, 4'h0, 6'd20, 32'h0);
        tick();
        checkOutput("hold_load_qa", qa, 32'h00001234);
        // Strobes low, addresses move, and an unstrobed write is attempted.
        applyStimulus(1'b0, 1'b0, 4'hF, 6'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 4'hF, 6'd9, 32'hFFFFFFFF);
        tick();
        tick();
        checkOutput("hold_qa", qa, 32'h00001234);
        checkOutput("hold_qb", qb, 32'h00001234);
        applyStimulus(1'b1, 1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 1'b1, 4'h0, 6'd9, 32'h0);
        tick();
        checkOutput("unstrobed_write_a_ignored", qa, 32'h11BB33DD);
        checkOutput("unstrobed_write_b_ignored", qb, 32'hBBBBAAAA);

        // ---- Reset restarted mid-clear ----
        reset = 1'b1;
        idlePorts();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        checkOutput("midclear_busy", {31'b0, init_busy}, 32'h1);
        reset = 1'b1;
        tick();
        checkOutput("restart_init_busy", {31'b0, init_busy}, 32'h1);
        reset = 1'b0;
        cnt   = 0;
        bad_a = 0;
        while (init_busy && cnt < 200) begin
            if (cnt == 40)
                applyStimulus(1'b1, 1'b0, 4'hF, 6'd0, 32'hCAFEF00D, 1'b1, 1'b1, 4'h0, 6'd20, 32'h0);
            else
                applyStimulus(1'b1, 1'b1, 4'h0, 6'd20, 32'h0, 1'b1, 1'b1, 4'h0, 6'd20, 32'h0);
            tick();
            cnt++;
            if (init_busy && (qa !== 32'h0 || qb !== 32'h0)) bad_a++;
        end
        checkOutput("clear2_cycles", cnt, 32'd64);
        checkOutput("clear2_q_nonzero_count", bad_a, 32'd0);
        applyStimulus(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 1'b1, 4'h0, 6'd20, 32'h0);
        tick();
        checkOutput("busy_write_not_stored", qa, 32'h0);
        checkOutput("clear2_addr20", qb, 32'h0);

        idlePorts();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
